// File: rtl/clk_div_gen.sv
// Multi-channel divided-clock / clock-enable generator with a lock monitor.
// Optional counter realign pulse is enabled by defining CLK_DIV_ALIGN_EN.
module clk_div_lane #(
  parameter int CNT_WIDTH = 16,
  parameter int DIV_INIT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_i,
  input  logic [CNT_WIDTH-1:0] val_i,
  input  logic                 align_i,
  output logic                 clk_out_o,
  output logic                 clk_en_o,
  output logic                 pend_o
);
  logic [CNT_WIDTH-1:0] div_q, div_d, shd_q, shd_d, cnt_q, cnt_d;
  logic                 pend_q, pend_d, out_q, out_d, en_q, en_d;
  logic                 wrap, restart, apply;

  always_comb begin
    wrap    = (div_q != '0) && (cnt_q == div_q - CNT_WIDTH'(1));
    restart = align_i || wrap || (div_q == '0);
    // a disabled channel picks up its new divisor on the very next edge
    apply   = pend_q && restart;
    div_d   = apply ? shd_q : div_q;
    shd_d   = wr_i ? val_i : shd_q;
    pend_d  = wr_i || (pend_q && !apply);
    cnt_d   = restart ? '0 : cnt_q + CNT_WIDTH'(1);
    en_d    = !align_i && wrap && (div_d != '0);
    // high phase opens on the wrap and closes once the counter reaches D/2
    if (align_i || (div_d < CNT_WIDTH'(2))) out_d = 1'b0;
    else if (wrap)                          out_d = 1'b1;
    else                                    out_d = out_q && (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= CNT_WIDTH'(DIV_INIT);
      shd_q  <= CNT_WIDTH'(DIV_INIT);
      cnt_q  <= '0;
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      shd_q  <= shd_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      en_q   <= en_d;
    end
  end

  assign clk_out_o = out_q;
  assign clk_en_o  = en_q;
  assign pend_o    = pend_q;
endmodule

module clk_div_gen #(
  parameter  int CHANNELS    = 4,
  parameter  int CNT_WIDTH   = 16,
  parameter  int DIV_INIT    = 2,
  parameter  int LOCK_CYCLES = 16,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_wr,
  input  logic [SEL_W-1:0]     div_sel,
  input  logic [CNT_WIDTH-1:0] div_val,
  input  logic                 align,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  clk_en,
  output logic                 locked
);
  localparam int               LK_W = $clog2(LOCK_CYCLES) + 1;
  localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(CHANNELS);

  typedef enum logic {S_COUNT, S_LOCKED} lock_st_e;

  lock_st_e            st_q, st_d;
  logic [LK_W-1:0]     lk_q, lk_d;
  logic [CHANNELS-1:0] pend, wr_ch;
  logic                wr_ok, align_eff;

  assign wr_ok = div_wr && ({1'b0, div_sel} < NCH);

`ifdef CLK_DIV_ALIGN_EN
  assign align_eff = align;
`else
  logic unused_align;
  assign unused_align = align;
  assign align_eff    = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign wr_ch[i] = wr_ok && (div_sel == SEL_W'(i));
    clk_div_lane #(.CNT_WIDTH(CNT_WIDTH), .DIV_INIT(DIV_INIT)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr_ch[i]),
      .val_i     (div_val),
      .align_i   (align_eff),
      .clk_out_o (clk_out[i]),
      .clk_en_o  (clk_en[i]),
      .pend_o    (pend[i])
    );
  end

  always_comb begin
    st_d = st_q;
    lk_d = lk_q;
    unique case (st_q)
      S_COUNT: begin
        if ((|pend) || wr_ok || align_eff) lk_d = '0;
        else if (lk_q == LK_W'(LOCK_CYCLES - 1)) begin
          st_d = S_LOCKED;
          lk_d = '0;
        end else lk_d = lk_q + LK_W'(1);
      end
      S_LOCKED: begin
        if (wr_ok || align_eff) begin
          st_d = S_COUNT;
          lk_d = '0;
        end
      end
      default: begin
        st_d = S_COUNT;
        lk_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= S_COUNT;
      lk_q <= '0;
    end else begin
      st_q <= st_d;
      lk_q <= lk_d;
    end
  end

  assign locked = (st_q == S_LOCKED);
endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed steps plus random writes, checked every edge
// against a model that tracks period start times and modular arithmetic.
module tb_clk_div_gen;
  localparam int CH    = 5;
  localparam int CW    = 16;
  localparam int DINIT = 2;
  localparam int LOCK  = 16;
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
`ifdef CLK_DIV_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div_wr = 1'b0;
  logic [SEL_W-1:0] div_sel = '0;
  logic [CW-1:0]    div_val = '0;
  logic             align = 1'b0;
  logic [CH-1:0]    clk_out, clk_en;
  logic             locked;

  clk_div_gen #(.CHANNELS(CH), .CNT_WIDTH(CW), .DIV_INIT(DINIT), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
    .align(align), .clk_out(clk_out), .clk_en(clk_en), .locked(locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // model: divisor, shadow, pending, edge index at which the current phase began,
  // and whether that edge was itself a strobe edge
  int md[CH], msh[CH], mstart[CH];
  bit mpend[CH], mlive[CH];
  int k, run;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
  endtask

  task automatic model_reset();
    k = 0;
    run = 0;
    for (int c = 0; c < CH; c++) begin
      md[c] = DINIT; msh[c] = DINIT; mstart[c] = 0; mpend[c] = 0; mlive[c] = 0;
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      bit en, out;
      int p;
      p = k - mstart[c];
      en = 0;
      out = 0;
      if (md[c] != 0) en = (p > 0 && (p % md[c]) == 0) || (p == 0 && mlive[c]);
      if (md[c] >= 2) out = (mlive[c] || p >= md[c]) && ((p % md[c]) < md[c] / 2);
      chk($sformatf("clk_en[%0d]@%0d", c, k), clk_en[c], en);
      chk($sformatf("clk_out[%0d]@%0d", c, k), clk_out[c], out);
    end
    chk($sformatf("locked@%0d", k), locked, run >= LOCK);
  endtask

  task automatic tick(input bit wr, input int sel, input int val, input bit al);
    bit anyp, qual, bnd;
    div_wr = wr; div_sel = sel[SEL_W-1:0]; div_val = val[CW-1:0]; align = al;
    @(posedge clk);
    k++;
    anyp = 0;
    for (int c = 0; c < CH; c++) if (mpend[c]) anyp = 1;
    qual = (wr && sel < CH) || (ALIGN_EN && al);
    for (int c = 0; c < CH; c++) begin
      bnd = (md[c] != 0) && (k > mstart[c]) && ((k - mstart[c]) % md[c] == 0);
      if (ALIGN_EN && al) begin
        if (mpend[c]) begin md[c] = msh[c]; mpend[c] = 0; end
        mstart[c] = k; mlive[c] = 0;
      end else if (mpend[c] && (bnd || md[c] == 0)) begin
        md[c] = msh[c]; mpend[c] = 0; mstart[c] = k; mlive[c] = bnd;
      end
      if (wr && sel == c) begin msh[c] = val; mpend[c] = 1; end
    end
    run = (anyp || qual) ? 0 : run + 1;
    #1;
    div_wr = 0; align = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge clk) rst = 0;

    idle(20);                                   // default D=2 everywhere, lock at edge 16
    tick(1, 1, 5, 0); idle(30);                 // ch1 -> 5
    tick(1, 2, 0, 0); idle(10);                 // ch2 silent
    tick(1, 2, 3, 0); idle(10);                 // ch2 restarts at 3
    tick(1, 3, 7, 0); tick(1, 3, 4, 0); idle(20); // last write wins
    tick(1, 0, 1, 0); idle(25);                 // ch0 constant strobe
    tick(1, 5, 9, 0); tick(1, 6, 0, 0); tick(1, 7, 3, 0); idle(3); // out-of-range selects

    // asynchronous reset in the middle of a period
    rst = 1;
    #1;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("rst_en[%0d]", c), clk_en[c], 1'b0);
      chk($sformatf("rst_out[%0d]", c), clk_out[c], 1'b0);
    end
    chk("rst_locked", locked, 1'b0);
    model_reset();
    @(negedge clk) rst = 0;
    idle(6);

    tick(1, 1, 3, 0); idle(1); tick(1, 2, 4, 0); idle(2); tick(1, 3, 6, 0);
    idle(30);
    tick(0, 0, 0, 1); idle(30);                 // align pulse
    tick(1, 4, 5, 1); idle(20);                 // align with coincident write

    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 9),
           $urandom_range(0, 29) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
